// File: rtl/mem_req_arbiter.sv
// rtl/mem_req_arbiter.sv - shares one memory port between inst and data requesters, routes responses in order
// Optional macro ARB_RR_EN: round-robin arbitration instead of fixed data-over-inst priority.
module mem_req_arbiter #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        resp_err
);

  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = PW + 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                     state, state_next;
  logic                       lock_src, lock_src_next;
  logic [MAX_OUTSTANDING-1:0] fifo;
  logic [PW-1:0]              rd_ptr, wr_ptr;
  logic [CW-1:0]              count;
  logic                       lock_valid, can_lock, any_req;
  logic                       arb_src, sel_src, req_int, grant, pop, head;

  assign lock_valid = (state == LOCKED);
  assign any_req    = inst_req || data_req;
  // A pending lock already owns a slot, so it counts against capacity.
  assign can_lock   = (count + CW'(lock_valid)) < CW'(MAX_OUTSTANDING);

`ifdef ARB_RR_EN
  logic rr_last;
  assign arb_src = (inst_req && data_req) ? ~rr_last : data_req;

  always_ff @(posedge clk) begin
    if (reset)      rr_last <= 1'b0;
    else if (grant) rr_last <= sel_src;
  end
`else
  assign arb_src = data_req;
`endif

  always_comb begin
    state_next    = state;
    lock_src_next = lock_src;
    sel_src       = lock_src;
    req_int       = 1'b0;
    case (state)
      IDLE: begin
        sel_src = arb_src;
        req_int = any_req && can_lock;
        if (req_int && !mem_addr_ok) begin
          state_next    = LOCKED;
          lock_src_next = arb_src;
        end
      end
      LOCKED: begin
        sel_src = lock_src;
        req_int = lock_src ? data_req : inst_req;
        if (req_int && mem_addr_ok) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (reset) req_int = 1'b0;
  end

  assign grant     = req_int && mem_addr_ok;
  assign mem_req   = req_int;
  assign mem_wr    = req_int && (sel_src ? data_wr : inst_wr);
  assign mem_size  = req_int ? (sel_src ? data_size  : inst_size)  : 2'b0;
  assign mem_addr  = req_int ? (sel_src ? data_addr  : inst_addr)  : 32'b0;
  assign mem_wstrb = req_int ? (sel_src ? data_wstrb : inst_wstrb) : 4'b0;
  assign mem_wdata = req_int ? (sel_src ? data_wdata : inst_wdata) : 32'b0;

  assign inst_addr_ok = grant && !sel_src;
  assign data_addr_ok = grant &&  sel_src;

  assign head         = fifo[rd_ptr];
  assign pop          = !reset && mem_data_ok && (count != '0);
  assign inst_data_ok = pop && !head;
  assign data_data_ok = pop &&  head;
  assign inst_rdata   = inst_data_ok ? mem_rdata : 32'b0;
  assign data_rdata   = data_data_ok ? mem_rdata : 32'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      lock_src <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      resp_err <= 1'b0;
    end else begin
      state    <= state_next;
      lock_src <= lock_src_next;
      if (grant) begin
        fifo[wr_ptr] <= sel_src;
        wr_ptr       <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({grant, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (mem_data_ok && count == '0) resp_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb/tb_mem_req_arbiter.sv - directed and randomized checks of mem_req_arbiter against a queue-based model
module tb_mem_req_arbiter;
  localparam int MAX = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic [3:0]  inst_wstrb, data_wstrb;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        mem_addr_ok, mem_data_ok, resp_err;

  int vectors = 0;
  int miscompares = 0;

  // model state: outstanding source IDs, pending lock, sticky error, last granted side
  bit m_q[$];
  bit m_lock, m_lock_src, m_err, m_rr_last;
  bit acc_inst, acc_data;

  always #5 clk = ~clk;

  mem_req_arbiter #(.MAX_OUTSTANDING(MAX)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .resp_err(resp_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks every output for the inputs currently driven, then advances the model one clock.
  task automatic step(input string tag);
    bit ereq, esrc, grant, epop, ehead;
    logic [38:0] efields;
    #1;
    esrc = 1'b0;
    if (reset) ereq = 1'b0;
    else if (m_lock) begin
      esrc = m_lock_src;
      ereq = esrc ? data_req : inst_req;
    end else begin
      ereq = (inst_req || data_req) && (m_q.size() < MAX);
`ifdef ARB_RR_EN
      if (inst_req && data_req) esrc = !m_rr_last;
      else esrc = data_req;
`else
      esrc = data_req;
`endif
    end
    efields = !ereq ? 39'b0 : esrc ? {data_wr, data_size, data_wstrb, data_wdata}
                                   : {inst_wr, inst_size, inst_wstrb, inst_wdata};
    grant = ereq && mem_addr_ok;
    epop  = !reset && mem_data_ok && (m_q.size() > 0);
    ehead = (m_q.size() > 0) ? m_q[0] : 1'b0;

    chk({tag, ".mem_req"}, 64'(mem_req), 64'(ereq));
    chk({tag, ".mem_addr"}, 64'(mem_addr), !ereq ? 64'(0) : esrc ? 64'(data_addr) : 64'(inst_addr));
    chk({tag, ".mem_fields"}, 64'({mem_wr, mem_size, mem_wstrb, mem_wdata}), 64'(efields));
    chk({tag, ".inst_addr_ok"}, 64'(inst_addr_ok), 64'(grant && !esrc));
    chk({tag, ".data_addr_ok"}, 64'(data_addr_ok), 64'(grant && esrc));
    chk({tag, ".inst_data_ok"}, 64'(inst_data_ok), 64'(epop && !ehead));
    chk({tag, ".data_data_ok"}, 64'(data_data_ok), 64'(epop && ehead));
    chk({tag, ".inst_rdata"}, 64'(inst_rdata), (epop && !ehead) ? 64'(mem_rdata) : 64'(0));
    chk({tag, ".data_rdata"}, 64'(data_rdata), (epop && ehead) ? 64'(mem_rdata) : 64'(0));
    chk({tag, ".resp_err"}, 64'(resp_err), 64'(m_err));

    acc_inst = grant && !esrc;
    acc_data = grant && esrc;
    if (reset) begin
      m_q.delete();
      m_lock = 0; m_lock_src = 0; m_err = 0; m_rr_last = 0;
    end else begin
      if (mem_data_ok) begin
        if (m_q.size() > 0) void'(m_q.pop_front());
        else m_err = 1;
      end
      if (grant) begin
        m_q.push_back(esrc);
        m_rr_last = esrc;
      end
      if (m_lock) begin
        if (grant) m_lock = 0;
      end else if (ereq && !mem_addr_ok) begin
        m_lock = 1;
        m_lock_src = esrc;
      end
    end
    @(negedge clk);
  endtask

  task automatic rand_inst();
    inst_addr = $urandom; inst_wr = 1'($urandom_range(1)); inst_size = 2'($urandom_range(2));
    inst_wstrb = 4'($urandom); inst_wdata = $urandom;
  endtask

  task automatic rand_data();
    data_addr = $urandom; data_wr = 1'($urandom_range(1)); data_size = 2'($urandom_range(2));
    data_wstrb = 4'($urandom); data_wdata = $urandom;
  endtask

  initial begin
    reset = 1; inst_req = 0; data_req = 0; mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = '0;
    inst_wr = 0; inst_size = 2; inst_addr = 0; inst_wstrb = 4'hf; inst_wdata = 0;
    data_wr = 0; data_size = 2; data_addr = 0; data_wstrb = 4'hf; data_wdata = 0;
    @(negedge clk);
    inst_req = 1; data_req = 1; mem_addr_ok = 1; mem_data_ok = 1;
    step("rst0");
    step("rst1");
    reset = 0; inst_req = 0; data_req = 0; mem_addr_ok = 0; mem_data_ok = 0;
    step("idle");

    // simultaneous requests: data first, then inst
    inst_req = 1; inst_addr = 32'h1000; data_req = 1; data_addr = 32'h2000; mem_addr_ok = 1;
    #1 chk("sim0.addr_const", 64'(mem_addr), 64'h2000);
    chk("sim0.data_ok_const", 64'(data_addr_ok), 64'h1);
    step("sim0");
    data_req = 0;
    #1 chk("sim1.addr_const", 64'(mem_addr), 64'h1000);
    chk("sim1.inst_ok_const", 64'(inst_addr_ok), 64'h1);
    step("sim1");
    inst_req = 0; mem_addr_ok = 0;

    // lock hold: inst raised while data is stalled
    data_req = 1; data_addr = 32'h3000;
    step("lock0");
    inst_req = 1; inst_addr = 32'h4000;
    step("lock1");
    #1 chk("lock2.addr_const", 64'(mem_addr), 64'h3000);
    chk("lock2.inst_ok_const", 64'(inst_addr_ok), 64'h0);
    step("lock2");
    mem_addr_ok = 1;
    step("lock_acc_d");
    data_req = 0;
    step("lock_acc_i");
    inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
    for (int i = 0; i < 4; i++) begin mem_rdata = 32'h100 + i; step("drain0"); end
    mem_data_ok = 0;

    // in-order routing
    mem_addr_ok = 1;
    inst_req = 1; step("ord_i0");
    inst_req = 0; data_req = 1; step("ord_d");
    data_req = 0; inst_req = 1; step("ord_i1");
    inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
    mem_rdata = 32'hA;
    #1 chk("ord.rdata_a", 64'(inst_rdata), 64'hA);
    step("ord_ra");
    mem_rdata = 32'hB;
    #1 chk("ord.rdata_b", 64'(data_rdata), 64'hB);
    step("ord_rb");
    mem_rdata = 32'hC;
    #1 chk("ord.rdata_c", 64'(inst_rdata), 64'hC);
    step("ord_rc");
    mem_data_ok = 0;
    step("ord_quiet");

    // full FIFO
    inst_req = 1; mem_addr_ok = 1;
    for (int i = 0; i < 4; i++) step("full_fill");
    #1 chk("full.mem_req_const", 64'(mem_req), 64'h0);
    step("full_hold");
    mem_data_ok = 1; mem_rdata = 32'h55;
    #1 chk("full.no_grant_const", 64'(inst_addr_ok), 64'h0);
    step("full_pop");
    mem_data_ok = 0;
    #1 chk("full.grant_const", 64'(inst_addr_ok), 64'h1);
    step("full_regrant");
    inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
    for (int i = 0; i < 4; i++) begin mem_rdata = $urandom; step("drain1"); end

    // empty-FIFO response
    step("empty_rsp");
    mem_data_ok = 0;
    #1 chk("empty.err_const", 64'(resp_err), 64'h1);
    step("empty_sticky");
    reset = 1; step("empty_rst");
    reset = 0;
    #1 chk("empty.err_clr_const", 64'(resp_err), 64'h0);
    step("after_rst");

    // reset while locked with two outstanding
    inst_req = 1; mem_addr_ok = 1;
    step("mid_a0"); step("mid_a1");
    inst_req = 0; data_req = 1; mem_addr_ok = 0;
    step("mid_lock");
    reset = 1; data_req = 0;
    step("mid_rst");
    reset = 0;
    step("mid_post");
    mem_data_ok = 1; step("mid_empty");
    mem_data_ok = 0; reset = 1; step("mid_rst2");
    reset = 0;

    // randomized traffic honouring the hold-until-accepted rule
    for (int n = 0; n < 500; n++) begin
      if (!inst_req && $urandom_range(1) == 1) begin inst_req = 1; rand_inst(); end
      if (!data_req && $urandom_range(1) == 1) begin data_req = 1; rand_data(); end
      mem_addr_ok = 1'($urandom_range(1));
      mem_data_ok = (m_q.size() > 0) && ($urandom_range(2) == 0);
      mem_rdata = $urandom;
      step("rand");
      if (acc_inst) inst_req = 0;
      if (acc_data) data_req = 0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
